// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU with valid/ready handshakes on both sides.
// AND/OR/ADD/SUB/SLT/NOP and undefined codes finish one cycle after accept.
// SLL shifts iteratively, one bit per cycle. The latency from the accept edge
// to out_valid is shamt+1 cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   request valid
//   in_ready     out  unit idle, can accept a request
//   alu_control  in   4-bit operation code
//   operand_a    in   first operand / shift source
//   operand_b    in   second operand; low SHAMT_W bits = shift amount for SLL
//   out_valid    out  result valid (held until out_ready)
//   out_ready    in   consumer accepts result
//   result       out  registered result
//   zero         out  registered (result == 0)
//   illegal      out  registered undefined-opcode flag
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_control,
  input  logic [XLEN-1:0]    operand_a,
  input  logic [XLEN-1:0]    operand_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic               illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]    XLEN_ZERO = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_acc;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_illegal;

  logic                w_accept;
  logic                w_slt;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [XLEN-1:0]     w_acc_shl;
  logic [XLEN-1:0]     w_op_result;
  logic                w_op_illegal;

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_slt     = ($signed(operand_a) < $signed(operand_b));
  assign w_shamt   = operand_b[SHAMT_W-1:0];
  assign w_acc_shl = {r_acc[XLEN-2:0], 1'b0};

  // Single-cycle operation result and illegal-code decode from the live inputs
  always_comb begin
    w_op_result  = XLEN_ZERO;
    w_op_illegal = 1'b0;
    case (alu_control)
      ALU_AND: w_op_result = operand_a & operand_b;
      ALU_OR:  w_op_result = operand_a | operand_b;
      ALU_ADD: w_op_result = operand_a + operand_b;
      ALU_SUB: w_op_result = operand_a - operand_b;
      ALU_SLT: w_op_result = {{(XLEN-1){1'b0}}, w_slt};
      // SLL goes through the iterative path; NOP yields zero, legal.
      ALU_SLL: w_op_result = XLEN_ZERO;
      ALU_NOP: w_op_result = XLEN_ZERO;
      default: w_op_illegal = 1'b1;
    endcase
  end

  // Control FSM with registered result, zero and illegal flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= XLEN_ZERO;
      r_cnt     <= CNT_ZERO;
      r_result  <= XLEN_ZERO;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (alu_control == ALU_SLL) begin
              r_acc <= operand_a;
              r_cnt <= w_shamt;
              if (w_shamt == CNT_ZERO) begin
                // A zero shift completes immediately with the unshifted source.
                r_result  <= operand_a;
                r_zero    <= (operand_a == XLEN_ZERO);
                r_illegal <= 1'b0;
                r_state   <= ST_DONE;
              end else begin
                r_state <= ST_SHIFT;
              end
            end else begin
              r_result  <= w_op_result;
              r_zero    <= (w_op_result == XLEN_ZERO);
              r_illegal <= w_op_illegal;
              r_state   <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_acc_shl;
          r_cnt <= r_cnt - CNT_ONE;
          // The last shift is published straight into the result register.
          if (r_cnt == CNT_ONE) begin
            r_result  <= w_acc_shl;
            r_zero    <= (w_acc_shl == XLEN_ZERO);
            r_illegal <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed vectors with literal expectations, plus a behavioural model that
// tracks when a result must appear and what it is. The model is checked
// against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ill(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1110, 4'b1111: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
    return (c == 4'b1110) ? (int'(b[4:0]) + 1) : 1;
  endfunction

  logic        m_busy;
  int          m_valid_at;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_ill;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a request occupies the unit from acceptance until drained; its result
  // is due 'latency' cycles after the accept edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy     <= 1'b0;
      m_valid_at <= 0;
      m_res      <= 32'd0;
      m_zero     <= 1'b0;
      m_ill      <= 1'b0;
    end else if (!m_busy && in_valid) begin
      m_busy     <= 1'b1;
      m_valid_at <= cyc + model_lat(alu_control, operand_b);
      m_res      <= model_res(alu_control, operand_a, operand_b);
      m_zero     <= (model_res(alu_control, operand_a, operand_b) == 32'd0);
      m_ill      <= model_ill(alu_control);
    end else if (m_busy && (cyc >= m_valid_at) && out_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Compare DUT against the model every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic exp_valid = m_busy && (cyc >= m_valid_at);
      check("cmp_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      check("cmp_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        check("cmp_result", result, m_res);
        check("cmp_zero", {31'd0, zero}, {31'd0, m_zero});
        check("cmp_illegal", {31'd0, illegal}, {31'd0, m_ill});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = v.code;
    operand_a   = v.a;
    operand_b   = v.b;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    // Inputs change after acceptance must not matter.
    in_valid    = 1'b0;
    alu_control = 4'b0010;
    operand_a   = ~v.a;
    operand_b   = ~v.b;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, v.lat);
    check("result_lit", result, v.res);
    check("zero_lit", {31'd0, zero}, {31'd0, v.z});
    check("illegal_lit", {31'd0, illegal}, {31'd0, v.ill});
    check("model_pin_res", m_res, v.res);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_result", result, v.res);
      check("hold_illegal", {31'd0, illegal}, {31'd0, v.ill});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 4'b0000;
    operand_a   = 32'd0;
    operand_b   = 32'd0;

    vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 0};
    vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 0};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, 0};
    vecs[3]  = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1, 0};
    vecs[4]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1, 0};
    vecs[5]  = '{4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1, 2};
    vecs[6]  = '{4'b1110, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 1'b0, 1'b0, 5, 0};
    vecs[7]  = '{4'b1110, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 0};
    vecs[8]  = '{4'b1110, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32, 0};
    vecs[9]  = '{4'b0100, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b1, 1, 10};
    vecs[10] = '{4'b1111, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0, 1, 0};
    vecs[11] = '{4'b1011, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b1, 1, 1};

    #23;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // In DONE a pending request is not accepted on the drain edge.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b0010; operand_a = 32'd2; operand_b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ovl_first", result, 32'd5);
    out_ready = 1'b1; in_valid = 1'b1;
    alu_control = 4'b0001; operand_a = 32'h100; operand_b = 32'h001;
    @(posedge clk);
    #1;
    check("ovl_drain_valid", {31'd0, out_valid}, 32'd0);
    check("ovl_drain_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("ovl_second_valid", {31'd0, out_valid}, 32'd1);
    check("ovl_second_res", result, 32'h101);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a long shift aborts it.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'b1110; operand_a = 32'd1; operand_b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_shift_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit alu_control code produced by the ALU control decoder and performs the selected operation on two operands. Single-cycle ops (AND/OR/ADD/SUB/SLT) return a registered result one cycle after acceptance. SLL runs as an iterative one-bit-per-cycle shifter. Uses valid/ready on both sides so the pipeline can stall on long shifts or downstream backpressure.

Parameters:
XLEN, 32, operand/result width
SHAMT_W, 5, shift-amount width; log2(XLEN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
alu_control  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1110 SLL, 1111 NOP
operand_a  input  XLEN  first operand / shift source
operand_b  input  XLEN  second operand; bits [SHAMT_W-1:0] are the shift amount for SLL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  registered result
zero  output  1  registered (result == 0), used for branch compare after SUB
illegal  output  1  registered flag: alu_control was an undefined code

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, shift counter=0. A reset during SHIFT or DONE aborts the op; no result is produced.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept = in_valid && in_ready. alu_control and operands are sampled only at the accept edge; later changes to the inputs are ignored.
- IDLE, accept, non-SLL code: compute, register result/zero/illegal, go DONE. out_valid is high on the cycle after the accept edge (latency 1).
  - AND: a&b. OR: a|b.
  - ADD: a+b, wraps mod 2^XLEN.
  - SUB: a-b, wraps mod 2^XLEN.
  - SLT: signed compare; 1 if $signed(a)<$signed(b), else 0, zero-extended to XLEN.
  - NOP (1111): result=0, illegal=0.
  - Undefined codes (0011, 0100, 0101, 1000-1101): result=0, illegal=1.
- IDLE, accept, SLL: load accumulator=a and counter=b[SHAMT_W-1:0]; upper bits of b are ignored.
  - Counter==0: result=a, go DONE directly (latency 1).
  - Otherwise go SHIFT.
- SHIFT: each edge shifts accumulator left by 1 (zero-fill) and decrements the counter. On the edge where the counter goes 1->0, register result/zero and go DONE. Total latency from accept edge to out_valid = shamt+1 cycles (shamt=31 -> 32 cycles). in_ready=0 throughout.
- DONE: result, zero and illegal are held stable while out_ready=0 (backpressure of any length). On out_valid && out_ready, go IDLE; out_valid drops next cycle. result/zero/illegal keep their last values in IDLE.
- Throughput: at most one op per 2 cycles. There is no overlap of accept and drain, so a simultaneous in_valid and out_ready in DONE accepts nothing new.
- zero is always computed from the final registered result, including for illegal and NOP ops (zero=1 there).

Test Plan:
- Reset mid-op: assert rst_n=0 during SHIFT of SLL shamt=20 -> out_valid=0, in_ready=1 immediately after release, no stale result emitted.
- ADD/SUB wrap: ADD a=0xFFFFFFFF, b=1 -> result=0, zero=1, out_valid 1 cycle after accept. SUB a=5, b=7 -> result=0xFFFFFFFE, zero=0.
- SLT signed: a=0xFFFFFFFF (-1), b=1 -> result=1. a=1, b=0xFFFFFFFF -> result=0.
- SLL iterative: a=0x00000003, b=0xFFFFFFE4 (shamt=4) -> result=0x30 with out_valid exactly 5 cycles after accept, in_ready=0 during.
- SLL boundaries: shamt=0 -> result=a in 1 cycle. a=1, shamt=31 -> 0x80000000 at 32 cycles.
- Backpressure/illegal: code 0100 with out_ready=0 for 10 cycles -> result=0, illegal=1, zero=1 held stable, in_ready=0. Raise out_ready -> IDLE next cycle. NOP 1111 -> illegal=0.
